// File: rtl/fft_agu_pkg.sv
// Shared types, legal parameter ranges and the twiddle mask helper for the FFT AGU.
package fft_agu_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int unsigned LOG2N_MIN    = 2;
  localparam int unsigned LOG2N_MAX    = 12;
  localparam int unsigned PIPE_LAT_MIN = 1;
  localparam int unsigned PIPE_LAT_MAX = 16;
  localparam int unsigned MASK_W       = 16;

  // Top s bits set within a width-bit field; higher bits are zero.
  function automatic logic [MASK_W-1:0] mask(input int unsigned s, input int unsigned width);
    logic [MASK_W-1:0] all_w;
    logic [MASK_W-1:0] low;
    all_w = (MASK_W'(1) << width) - MASK_W'(1);
    low   = (MASK_W'(1) << (width - s)) - MASK_W'(1);
    return all_w & ~low;
  endfunction

endpackage

// File: rtl/fft_agu_param_rotl.sv
// Combinational WIDTH-bit rotate-left by amt (amt < WIDTH).
module rotate_left_param
  import fft_agu_pkg::*;
#(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned AMT_W = 3
) (
  input  logic [WIDTH-1:0] din,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] dout
);

  logic [2*WIDTH-1:0] dbl;

  // Upper half of the shifted doubled word is the rotation.
  assign dbl  = {din, din} << amt;
  assign dout = dbl[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/fft_agu_param.sv
// Radix-2 in-place FFT address generator: stage/butterfly sequencing,
// twiddle addressing and a write-back delay line matched to the butterfly pipe.
module fft_agu_param
  import fft_agu_pkg::*;
#(
  parameter int unsigned LOG2N    = 5,
  parameter int unsigned PIPE_LAT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_fft,
  input  logic             stall,
  output logic [LOG2N-1:0] mema_address,
  output logic [LOG2N-1:0] memb_address,
  output logic [LOG2N-2:0] twiddle_address,
  output logic             rd_valid,
  output logic [LOG2N-1:0] wr_a_address,
  output logic [LOG2N-1:0] wr_b_address,
  output logic             mem_write,
  output logic             busy,
  output logic             fft_done
);

  localparam int unsigned J_W  = LOG2N - 1;
  localparam int unsigned S_W  = $clog2(LOG2N);
  localparam int unsigned D_W  = $clog2(PIPE_LAT + 1);

  if (LOG2N < LOG2N_MIN || LOG2N > LOG2N_MAX ||
      PIPE_LAT < PIPE_LAT_MIN || PIPE_LAT > PIPE_LAT_MAX) begin : g_bad_param
    $error("fft_agu_param: LOG2N or PIPE_LAT out of legal range");
  end

  state_t         state, state_n;
  logic [S_W-1:0] s_q, s_n;
  logic [J_W-1:0] j_q, j_n;
  logic [D_W-1:0] d_q, d_n;
  logic           start_q;
  logic [LOG2N-1:0] rot_a, rot_b;
  logic [J_W-1:0]   tw_mask;

  // State, counters and start edge register; all frozen by stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      s_q     <= '0;
      j_q     <= '0;
      d_q     <= '0;
      start_q <= 1'b0;
    end else if (!stall) begin
      state   <= state_n;
      s_q     <= s_n;
      j_q     <= j_n;
      d_q     <= d_n;
      start_q <= start_fft;
    end
  end

  always_comb begin
    state_n = state;
    s_n     = s_q;
    j_n     = j_q;
    d_n     = d_q;
    case (state)
      IDLE: begin
        if (start_fft && !start_q) begin
          s_n     = '0;
          j_n     = '0;
          d_n     = '0;
          state_n = RUN;
        end
      end
      RUN: begin
        if (j_q == '1) begin
          j_n     = '0;
          state_n = DRAIN;
        end else begin
          j_n = j_q + J_W'(1);
        end
      end
      DRAIN: begin
        // Hold off the next stage until the last write of this one has landed.
        if (d_q == D_W'(PIPE_LAT - 1)) begin
          d_n = '0;
          if (s_q == S_W'(LOG2N - 1)) begin
            state_n = DONE;
          end else begin
            s_n     = s_q + S_W'(1);
            state_n = RUN;
          end
        end else begin
          d_n = d_q + D_W'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  rotate_left_param #(.WIDTH(LOG2N), .AMT_W(S_W)) u_rot_a (
    .din  ({j_q, 1'b0}),
    .amt  (s_q),
    .dout (rot_a)
  );

  rotate_left_param #(.WIDTH(LOG2N), .AMT_W(S_W)) u_rot_b (
    .din  ({j_q, 1'b1}),
    .amt  (s_q),
    .dout (rot_b)
  );

  assign tw_mask = J_W'(mask(32'(s_q), J_W));

  // Addresses are gated so that idle/drain cycles present zero.
  assign rd_valid        = (state == RUN);
  assign busy            = (state == RUN) || (state == DRAIN);
  assign fft_done        = (state == DONE);
  assign mema_address    = rd_valid ? rot_a : '0;
  assign memb_address    = rd_valid ? rot_b : '0;
  assign twiddle_address = rd_valid ? (j_q & tw_mask) : '0;

  for (genvar g = 0; g < PIPE_LAT; g++) begin : g_dl
    logic [LOG2N-1:0] a;
    logic [LOG2N-1:0] b;
    logic             v;
    if (g == 0) begin : g_head
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a <= '0;
          b <= '0;
          v <= 1'b0;
        end else if (!stall) begin
          a <= mema_address;
          b <= memb_address;
          v <= rd_valid;
        end
      end
    end else begin : g_tail
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a <= '0;
          b <= '0;
          v <= 1'b0;
        end else if (!stall) begin
          a <= g_dl[g-1].a;
          b <= g_dl[g-1].b;
          v <= g_dl[g-1].v;
        end
      end
    end
  end

  assign wr_a_address = g_dl[PIPE_LAT-1].a;
  assign wr_b_address = g_dl[PIPE_LAT-1].b;
  assign mem_write    = g_dl[PIPE_LAT-1].v;

endmodule
